// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate cache with one word per line.
// A miss on a dirty line writes the victim back before the line is refilled.
module cache #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LINES      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic                  evict_pulse
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

  state_t state;

  logic [LINES-1:0]      valid_bits;
  logic [LINES-1:0]      dirty_bits;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [WORD_WIDTH-1:0] data_mem [LINES];

  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;

  logic [IDX_BITS-1:0]   cpu_idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic [IDX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  lookup_hit;

  // Lookup uses the live request in IDLE; later states work from the latched copy.
  assign cpu_idx    = cpu_addr[IDX_BITS-1:0];
  assign cpu_tag    = cpu_addr[ADDR_WIDTH-1:IDX_BITS];
  assign req_idx    = req_addr[IDX_BITS-1:0];
  assign req_tag    = req_addr[ADDR_WIDTH-1:IDX_BITS];
  assign lookup_hit = valid_bits[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      valid_bits  <= '0;
      dirty_bits  <= '0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      evict_pulse <= 1'b0;
    end else begin
      cpu_ready   <= 1'b0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      evict_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            if (lookup_hit) begin
              if (cpu_we) begin
                data_mem[cpu_idx]   <= cpu_wdata;
                dirty_bits[cpu_idx] <= 1'b1;
                cpu_rdata           <= cpu_wdata;
              end else begin
                cpu_rdata <= data_mem[cpu_idx];
              end
              cpu_ready <= 1'b1;
              hit_pulse <= 1'b1;
              state     <= RESPOND;
            end else if (valid_bits[cpu_idx] && dirty_bits[cpu_idx]) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[cpu_idx], cpu_idx};
              mem_wdata <= data_mem[cpu_idx];
              state     <= WRITEBACK;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= cpu_addr;
              state    <= FILL;
            end
          end
        end

        WRITEBACK: begin
          if (mem_req && mem_ready) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            evict_pulse <= 1'b1;
            state       <= FILL;
          end
        end

        // Entered from WRITEBACK with mem_req low, so the fill request starts one cycle later.
        FILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= req_addr;
          end else if (mem_ready) begin
            mem_req             <= 1'b0;
            valid_bits[req_idx] <= 1'b1;
            tag_mem[req_idx]    <= req_tag;
            if (req_we) begin
              data_mem[req_idx]   <= req_wdata;
              dirty_bits[req_idx] <= 1'b1;
              cpu_rdata           <= req_wdata;
            end else begin
              data_mem[req_idx]   <= mem_rdata;
              dirty_bits[req_idx] <= 1'b0;
              cpu_rdata           <= mem_rdata;
            end
            cpu_ready  <= 1'b1;
            miss_pulse <= 1'b1;
            state      <= RESPOND;
          end
        end

        RESPOND: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache.sv
// Testbench for cache: directed scenarios plus random traffic, checked by
// scoreboards fed from a line-level reference model and a behavioural memory.
module tb_cache;

  localparam int WORD_WIDTH = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int LINES      = 64;

  typedef struct {
    logic [7:0] rdata;
    bit         check_rdata;
    bit         hit;
    int         evicts;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } mem_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        evict_pulse;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  bit mem_hold = 1'b0;

  resp_t exp_resp_q[$];
  mem_t  exp_mem_q[$];
  int    exp_evicts = 0;
  int    evict_seen = 0;

  logic [7:0]  phys_mem  [logic [31:0]];
  logic [7:0]  model_mem [logic [31:0]];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [31:0] m_tag   [LINES];
  logic [7:0]  m_data  [LINES];

  cache #(
    .WORD_WIDTH(WORD_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINES(LINES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .evict_pulse(evict_pulse)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else begin
      checks_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_unexpected(input string name, input logic [31:0] actual);
    checks_total++;
    checks_failed++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, actual);
  endtask

  function automatic logic [7:0] mem_default(input logic [31:0] a);
    return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] phys_read(input logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return mem_default(a);
  endfunction

  function automatic logic [7:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return mem_default(a);
  endfunction

  // Reference model: one access against the line arrays, queueing expected traffic.
  task automatic model_access(input bit we, input logic [31:0] addr, input logic [7:0] wdata, output bit hit);
    logic [31:0] idx32;
    logic [31:0] tag;
    int          idx;
    resp_t       r;
    mem_t        m;
    idx32 = addr % LINES;
    idx   = int'(idx32);
    tag   = addr / LINES;
    hit   = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        m.we    = 1'b1;
        m.addr  = m_tag[idx] * LINES + idx32;
        m.wdata = m_data[idx];
        exp_mem_q.push_back(m);
        model_mem[m.addr] = m.wdata;
        exp_evicts++;
      end
      m.we    = 1'b0;
      m.addr  = addr;
      m.wdata = '0;
      exp_mem_q.push_back(m);
      m_data[idx]  = model_read(addr);
      m_dirty[idx] = 1'b0;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    if (we) begin
      m_data[idx]  = wdata;
      m_dirty[idx] = 1'b1;
    end
    r.rdata       = m_data[idx];
    r.check_rdata = !we;
    r.hit         = hit;
    r.evicts      = exp_evicts;
    exp_resp_q.push_back(r);
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_resp_q.delete();
    exp_mem_q.delete();
  endtask

  // Issues one request, scribbles on the cpu inputs while busy, and waits for completion.
  task automatic apply_stimulus(input bit we, input logic [31:0] addr, input logic [7:0] wdata);
    bit hit;
    int n;
    model_access(we, addr, wdata, hit);
    @(negedge clock);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(negedge clock);
    cpu_req   = 1'($urandom_range(0, 1));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = $urandom;
    cpu_wdata = 8'($urandom);
    n = 0;
    while (!cpu_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_output("ready_seen", 32'(cpu_ready), 32'd1);
    if (hit) check_output("hit_latency", 32'(n), 32'd0);
    @(negedge clock);
    cpu_req = 1'b0;
  endtask

  // Memory responder: serves requests after a random delay and checks them against the model.
  initial begin : mem_responder
    int   wait_cnt;
    int   latency;
    mem_t e;
    wait_cnt = 0;
    latency  = 1;
    forever begin
      @(negedge clock);
      if (mem_ready) mem_ready = 1'b0;
      else if (reset) wait_cnt = 0;
      else if (mem_req && !mem_hold) begin
        if (wait_cnt < latency) wait_cnt++;
        else begin
          if (exp_mem_q.size() == 0) report_unexpected("unexpected_mem_req", mem_addr);
          else begin
            e = exp_mem_q.pop_front();
            check_output("mem_we", 32'(mem_we), 32'(e.we));
            check_output("mem_addr", mem_addr, e.addr);
            if (e.we) check_output("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          end
          if (mem_we) begin
            phys_mem[mem_addr] = mem_wdata;
            mem_rdata = 8'($urandom);
          end else begin
            mem_rdata = phys_read(mem_addr);
          end
          mem_ready = 1'b1;
          wait_cnt  = 0;
          latency   = $urandom_range(0, 3);
        end
      end
    end
  end

  // Response monitor: pops the expected response whenever cpu_ready is seen.
  initial begin : resp_monitor
    resp_t r;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (evict_pulse) evict_seen++;
        if ((hit_pulse || miss_pulse) && !cpu_ready)
          report_unexpected("pulse_without_ready", {30'd0, hit_pulse, miss_pulse});
        if (cpu_ready) begin
          if (exp_resp_q.size() == 0) report_unexpected("unexpected_cpu_ready", 32'(cpu_rdata));
          else begin
            r = exp_resp_q.pop_front();
            check_output("hit_pulse", 32'(hit_pulse), 32'(r.hit));
            check_output("miss_pulse", 32'(miss_pulse), 32'(!r.hit));
            check_output("evict_count", 32'(evict_seen), 32'(r.evicts));
            if (r.check_rdata) check_output("cpu_rdata", 32'(cpu_rdata), 32'(r.rdata));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    checks_total++;
    checks_failed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] addr;
    phys_mem[32'h10]  = 8'hAB;
    model_mem[32'h10] = 8'hAB;
    model_reset();

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_output("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check_output("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check_output("rst_mem_req", 32'(mem_req), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'd0);
    check_output("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("rst_hit_pulse", 32'(hit_pulse), 32'd0);
    check_output("rst_miss_pulse", 32'(miss_pulse), 32'd0);
    check_output("rst_evict_pulse", 32'(evict_pulse), 32'd0);
    reset = 1'b0;

    apply_stimulus(1'b0, 32'h10, 8'h00);
    apply_stimulus(1'b0, 32'h10, 8'h00);
    apply_stimulus(1'b1, 32'h10, 8'h5C);
    apply_stimulus(1'b0, 32'h10, 8'h00);
    apply_stimulus(1'b0, 32'h50, 8'h00);
    check_output("phys_0x10_after_evict", 32'(phys_read(32'h10)), 32'h5C);
    apply_stimulus(1'b1, 32'h20, 8'h77);
    apply_stimulus(1'b0, 32'h20, 8'h00);
    apply_stimulus(1'b0, 32'h60, 8'h00);
    check_output("phys_0x20_after_evict", 32'(phys_read(32'h20)), 32'h77);

    // Reset while a fill for 0x50 is outstanding; the request must be abandoned.
    apply_stimulus(1'b0, 32'h10, 8'h00);
    mem_hold = 1'b1;
    begin
      bit hit;
      model_access(1'b0, 32'h50, 8'h00, hit);
    end
    @(negedge clock);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h50;
    @(negedge clock);
    cpu_req = 1'b0;
    repeat (3) @(negedge clock);
    check_output("fill_pending_req", 32'(mem_req), 32'd1);
    check_output("fill_pending_we", 32'(mem_we), 32'd0);
    check_output("fill_pending_addr", mem_addr, 32'h50);
    reset = 1'b1;
    @(negedge clock);
    check_output("mem_req_after_reset", 32'(mem_req), 32'd0);
    check_output("cpu_ready_after_reset", 32'(cpu_ready), 32'd0);
    reset = 1'b0;
    model_reset();
    mem_hold = 1'b0;
    repeat (4) @(negedge clock);
    apply_stimulus(1'b0, 32'h10, 8'h00);

    for (int i = 0; i < 300; i++) begin
      addr = ($urandom_range(0, 3) * LINES) + $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) addr[31:28] = 4'($urandom);
      apply_stimulus(1'($urandom_range(0, 1)), addr, 8'($urandom));
    end

    repeat (6) @(negedge clock);
    check_output("resp_queue_empty", 32'(exp_resp_q.size()), 32'd0);
    check_output("mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Direct-mapped, write-back, write-allocate cache with one word per line.
- Sits between a requester port (CPU side, data or instruction) and a next-level memory port.
- The same module is instantiated once for data and once for instructions.
- Provides single-cycle hit/miss/evict event pulses for external statistics monitors.

Parameters:
- WORD_WIDTH, 8, data word width in bits.
- ADDR_WIDTH, 32, word address width in bits.
- LINES, 64, number of cache lines (power of 2); IDX_BITS = log2(LINES).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request valid, sampled in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  word address.
- cpu_wdata  in  WORD_WIDTH  write data.
- cpu_rdata  out  WORD_WIDTH  read data, valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  next-level request, held until mem_ready.
- mem_we  out  1  next-level write (writeback).
- mem_addr  out  ADDR_WIDTH  next-level address.
- mem_wdata  out  WORD_WIDTH  writeback data.
- mem_rdata  in  WORD_WIDTH  fill data, valid with mem_ready.
- mem_ready  in  1  next-level completion, one cycle.
- hit_pulse  out  1  high with cpu_ready on a hit.
- miss_pulse  out  1  high with cpu_ready on a miss.
- evict_pulse  out  1  one cycle when a dirty-line writeback completes.

Behaviour:
- Address split: index = cpu_addr[IDX_BITS-1:0]; tag = cpu_addr[ADDR_WIDTH-1:IDX_BITS].
- Each line holds valid, dirty, tag and data.
- Reset: all valid and dirty bits cleared; state = IDLE; every output is 0. Data and tag arrays need no reset.
- States: IDLE, WRITEBACK, FILL, RESPOND.
- IDLE, request sampled (cpu_req = 1):
  - Latch we, addr and wdata; the cpu_* inputs are ignored until cpu_ready.
  - Hit (valid and tag match): read returns the line data; write updates the data and sets dirty. Go to RESPOND with hit_pulse.
  - Miss with a valid, dirty victim: go to WRITEBACK.
  - Any other miss: go to FILL.
- WRITEBACK: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index}, mem_wdata = victim data, all held stable. On the edge where mem_ready = 1: evict_pulse for one cycle, then FILL.
- FILL: mem_req = 1, mem_we = 0, mem_addr = latched addr. On the edge where mem_ready = 1:
  - Install valid = 1, the new tag, and data = mem_rdata.
  - Read: dirty = 0 and cpu_rdata = mem_rdata.
  - Write: data = latched wdata, dirty = 1.
  - Go to RESPOND with miss_pulse.
- RESPOND: cpu_ready = 1 for exactly one cycle, with cpu_rdata and the hit/miss pulse. A cpu_req in this cycle is not accepted; next state is IDLE.
- Latency: hit request sampled at edge N gives cpu_ready high during cycle N+1. The next request can be sampled at edge N+2.
- mem_req is deasserted in the cycle after mem_ready is sampled, then reasserted for FILL from the next state.
- mem_ready while mem_req = 0 is ignored.
- A write hit or write miss never writes through to memory. Dirty data leaves the cache only via eviction.
- cpu_rdata holds its last value outside RESPOND (don't care); it is 0 after reset.
- Reset mid-operation (any state): abandon immediately, mem_req = 0 next cycle, no cpu_ready for the pending request, all lines invalidated (dirty data is lost).
- Request to the same index as the victim: the writeback always precedes the fill; the victim address is never re-read.

Test Plan:
- Reset; read 0x10; memory returns 0xAB -> mem_req with mem_we = 0 at 0x10, then cpu_ready with cpu_rdata = 0xAB and miss_pulse = 1; no mem write.
- Read 0x10 again -> cpu_ready one cycle after the request, rdata 0xAB, hit_pulse = 1, mem_req stays 0.
- Write 0x10 with 0x5C, then read 0x10 -> both hit, rdata 0x5C, no mem traffic.
- Read 0x50 (same index, LINES = 64) -> writeback mem_we = 1, addr 0x10, wdata 0x5C, evict_pulse; then fill read at 0x50, miss_pulse.
- Write miss to clean 0x20 with 0x77, then read 0x20 -> fill read at 0x20, no mem write, read hits with 0x77. A conflict read at 0x60 then writes back 0x77 to 0x20.
- Assert reset during FILL for 0x50 -> mem_req 0 next cycle, no cpu_ready. A subsequent read of 0x10 misses, with no writeback.
